jiajian_arb: RTL
================

Name: jiajian_arb

Overview:
- Shares one registered 6-bit add/subtract unit between two requesters.
- Uses round-robin arbitration and a three-state sequencer: accept, execute, return.
- Each requester presents operands and an op select, and receives a grant pulse on acceptance and a done pulse when the result is on the shared result bus.
- Sits between two control masters and the arithmetic datapath.

Parameters:
- W, 6, operand width; result width is W+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 request (level).
- a0  input  W  requester 0 operand a.
- b0  input  W  requester 0 operand b.
- sl0  input  2  requester 0 op: 00 add, 11 subtract, 01/10 illegal.
- req1  input  1  requester 1 request (level).
- a1  input  W  requester 1 operand a.
- b1  input  W  requester 1 operand b.
- sl1  input  2  requester 1 op, same encoding as sl0.
- gnt0  output  1  one-cycle pulse: requester 0 operands captured.
- gnt1  output  1  one-cycle pulse: requester 1 operands captured.
- done0  output  1  one-cycle pulse: c/err valid for requester 0.
- done1  output  1  one-cycle pulse: c/err valid for requester 1.
- c  output  W+1  shared result register.
- err  output  1  set with done when the captured sl was illegal.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset values: gnt0=gnt1=done0=done1=0, c=0, err=0, busy=0, state=IDLE, rr pointer last=1 (so requester 0 wins first).
- States: IDLE, EXEC, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one of req0/req1 high at the edge: capture that requester's a, b, sl and its id; go to EXEC; drive the matching gnt high for the next cycle.
- IDLE, both requests high: grant the requester not equal to last; update last to the granted id.
- EXEC: one cycle. At its closing edge, load c and err, go to DONE.
  - sl=00: c = zero-extended a + b, (W+1)-bit, no overflow lost.
  - sl=11: c = (a - b) mod 2^(W+1); two's complement if negative.
  - sl=01/10: c=0, err=1. All other ops: err=0.
- DONE: the matching done is high for exactly this cycle; c/err valid. Unconditionally return to IDLE.
- c and err hold their value until the next EXEC completes.
- Timing: request sampled at edge of cycle N → gnt in cycle N+1 → done in cycle N+2 → IDLE in cycle N+3. Earliest next gnt is cycle N+4, so maximum throughput is one op per 3 cycles.
- Requests are not sampled in EXEC or DONE.
- A req still high when the FSM returns to IDLE is a new request. Requesters must drop req in their gnt cycle to avoid a repeat.
- Operands and sl are only sampled at the accepting edge; later changes have no effect on the op in flight.
- gnt0 and gnt1 are never high together; likewise done0 and done1.
- busy = (state != IDLE).
- rst in any state: next cycle matches reset values. The in-flight op is discarded and no done is issued for it. last returns to 1.

Test Plan:
- Single add: after reset, req0=1, a0=6'd63, b0=6'd63, sl0=00 for one cycle → gnt0 next cycle; done0 one cycle later with c=7'd126, err=0; gnt1/done1 stay 0.
- Negative subtract: req1, a1=3, b1=5, sl1=11 → gnt1, then done1 with c=7'h7E, err=0. Also a1=5, b1=3 → c=7'd2.
- Arbitration: req0 and req1 held high together for 12 cycles after reset → grant order 0,1,0,1. gnt pulses 3 cycles apart, each done exactly 1 cycle after its gnt with the correct result.
- Illegal op: req0, sl0=01, a0=10, b0=2 → done0 with c=0, err=1. Next legal op clears err.
- Reset mid-op: req0 accepted, assert rst during the EXEC cycle → no done0 ever for that op; c=0, busy=0 after reset; next simultaneous request is granted to requester 0.
- Operand stability: change a0 in the gnt0 cycle → result uses the originally captured a0. busy is high exactly over the gnt and done cycles.

Source files
------------

// File: rtl/jiajian_arb.sv
// Two-requester round-robin front end for one shared registered W-bit add/subtract unit.
// Sequencer walks IDLE -> EXEC -> DONE, so one operation completes every three cycles at best.
module jiajian_arb #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic [1:0]   sl0,
   input  logic         req1,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   input  logic [1:0]   sl1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         done0,
   output logic         done1,
   output logic [W:0]   c,
   output logic         err,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t       state_q, state_d;
   logic         last_q, last_d;
   logic         id_q, id_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic [1:0]   sl_q, sl_d;
   logic [W:0]   c_q, c_d;
   logic         err_q, err_d;
   logic         gnt0_q, gnt0_d;
   logic         gnt1_q, gnt1_d;
   logic         done0_q, done0_d;
   logic         done1_q, done1_d;
   logic         busy_q, busy_d;
   logic         gid_s;
   logic [W+1:0] res_s;

   // Result packed as {err, c}; illegal op codes yield a zero result with err set.
   function automatic logic [W+1:0] alu_f(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [1:0]   sl);
      logic [W+1:0] r;
      r = {(W+2){1'b0}};
      case (sl)
         2'b00:   r = {1'b0, {1'b0, a} + {1'b0, b}};
         2'b11:   r = {1'b0, {1'b0, a} - {1'b0, b}};
         default: r = {1'b1, {(W+1){1'b0}}};
      endcase
      return r;
   endfunction

   // Next-state, arbitration and registered-output computation.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      sl_d    = sl_q;
      c_d     = c_q;
      err_d   = err_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      gid_s   = 1'b0;
      res_s   = {(W+2){1'b0}};
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // Under contention the requester that did not win last time goes first.
               if (req0 && req1) begin
                  gid_s  = ~last_q;
                  last_d = ~last_q;
               end else begin
                  gid_s  = req1;
               end
               state_d = EXEC;
               id_d    = gid_s;
               a_d     = gid_s ? a1 : a0;
               b_d     = gid_s ? b1 : b0;
               sl_d    = gid_s ? sl1 : sl0;
               gnt0_d  = ~gid_s;
               gnt1_d  = gid_s;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            res_s   = alu_f(a_q, b_q, sl_q);
            c_d     = res_s[W:0];
            err_d   = res_s[W+1];
            done0_d = ~id_q;
            done1_d = id_q;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset discards any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         a_q     <= {W{1'b0}};
         b_q     <= {W{1'b0}};
         sl_q    <= 2'b00;
         c_q     <= {(W+1){1'b0}};
         err_q   <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sl_q    <= sl_d;
         c_q     <= c_d;
         err_q   <= err_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt0  = gnt0_q;
   assign gnt1  = gnt1_q;
   assign done0 = done0_q;
   assign done1 = done1_q;
   assign c     = c_q;
   assign err   = err_q;
   assign busy  = busy_q;

endmodule
